imem_fetch_ctrl: RTL

Fetch sequencer for the instruction memory. It owns the program counter, drives the word address into the combinational-read instruction memory, and registers each fetched word toward decode with a valid/ready handshake. It accepts branch/jump redirects from execute, stops on an all-zero word (end-of-program padding), and flags out-of-range fetches. It sits between InstructionMemoryi and the decode stage of the RISC core.

---
 rtl/imem_fetch_pkg.sv | 15 +
 rtl/instruction_memory_i.sv | 33 +++
 rtl/imem_fetch_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/imem_fetch_pkg.sv
// rtl/imem_fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
// Purpose: fetch state encoding and the end-of-program word used by imem_fetch_ctrl.
package imem_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  // An all-zero word marks end-of-program padding in the instruction memory.
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

endpackage

// File: rtl/instruction_memory_i.sv
// rtl/instruction_memory_i.sv - word-addressed instruction memory, combinational read
// Purpose: instruction store feeding the fetch sequencer.
// Ports:
//   clka        clock for the write port
//   wea         write enable (program load)
//   waddr/dina  write word address / data
//   addra       read word address
//   douta       read data, combinational; zero for addresses beyond MemSize-1
module InstructionMemoryi #(
  parameter int size    = 32,
  parameter int MemSize = 128
) (
  input  logic            clka,
  input  logic            wea,
  input  logic [size-1:0] waddr,
  input  logic [size-1:0] dina,
  input  logic [size-1:0] addra,
  output logic [size-1:0] douta
);

  localparam int AW = $clog2(MemSize);

  logic [size-1:0] mem [MemSize];

  always_ff @(posedge clka) begin
    if (wea && (waddr < size'(MemSize))) begin
      mem[waddr[AW-1:0]] <= dina;
    end
  end

  assign douta = (addra < size'(MemSize)) ? mem[addra[AW-1:0]] : '0;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - program counter and fetch register between instruction memory and decode
// Purpose: owns the PC, addresses the combinational instruction memory, registers each
// fetched word toward decode with a valid/ready handshake, handles redirects, stops on an
// all-zero word and faults on out-of-range fetches.
// Ports:
//   clka, rsta            clock; synchronous active-low reset
//   start                 pulse: leave IDLE/HALT/FAULT and fetch from RESET_PC
//   imem_addr/imem_data   word address out (= pc), instruction word in (same cycle)
//   if_valid/if_ready     handshake toward decode
//   if_instr/if_pc        registered instruction and the address it came from
//   br_valid/br_target    redirect from execute (absolute word address)
//   halted/fault          HALT / FAULT state flags
//   instr_count           completed decode handshakes, wraps
import imem_fetch_pkg::*;

module imem_fetch_ctrl #(
  parameter int              size     = 32,
  parameter int              MemSize  = 128,
  parameter logic [size-1:0] RESET_PC = '0
) (
  input  logic            clka,
  input  logic            rsta,
  input  logic            start,
  output logic [size-1:0] imem_addr,
  input  logic [size-1:0] imem_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [size-1:0] if_instr,
  output logic [size-1:0] if_pc,
  input  logic            br_valid,
  input  logic [size-1:0] br_target,
  output logic            halted,
  output logic            fault,
  output logic [31:0]     instr_count
);

  fetch_state_e    state_q, state_d;
  logic [size-1:0] pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [size-1:0] if_instr_q, if_instr_d;
  logic [size-1:0] if_pc_q, if_pc_d;
  logic [31:0]     count_q, count_d;
  logic            slot_free;

  // The output register can take a new word when it is empty or being consumed now.
  assign slot_free = !if_valid_q || if_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    count_d    = count_q;

    // A handshake completes regardless of what else happens this edge, flush included.
    if (if_valid_q && if_ready) begin
      count_d = count_q + 32'd1;
    end

    case (state_q)
      RUN: begin
        if (br_valid) begin
          pc_d       = br_target;
          if_valid_d = 1'b0;
        end else if (slot_free) begin
          if (pc_q >= size'(MemSize)) begin
            state_d    = FAULT;
            if_valid_d = 1'b0;
          end else if (imem_data == size'(HALT_WORD)) begin
            // The padding word itself is never handed to decode.
            state_d    = HALT;
            if_valid_d = 1'b0;
          end else begin
            if_instr_d = imem_data;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          state_d    = RUN;
          pc_d       = RESET_PC;
          if_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clka) begin
    if (!rsta) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign halted      = (state_q == HALT);
  assign fault       = (state_q == FAULT);
  assign instr_count = count_q;

endmodule
